// File: rtl/trap_peak_picker.sv
// Pulse-height picker for the trapezoidal filter stream: finds rising threshold crossings,
// samples the flat-top a programmable delay later and emits one AXI-Stream beat per clean event.
module trap_peak_picker #(
   parameter int DATA_WIDTH = 32,
   parameter int TS_WIDTH   = 32
) (
   input  logic                         clk,
   input  logic                         aresetn,
   input  logic signed [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                         s_axis_tvalid,
   input  logic signed [DATA_WIDTH-1:0] threshold,
   input  logic [13:0]                  flat_delay,
   input  logic [13:0]                  holdoff,
   output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [TS_WIDTH-1:0]          m_axis_tuser,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [15:0]                  pileup_count,
   output logic [15:0]                  drop_count,
   output logic [1:0]                   dbg_state
);

   // Output handshake: a beat transfers on any cycle with m_axis_tvalid & m_axis_tready;
   // tvalid/tdata/tuser hold steady until then and tvalid never looks at tready.
   // The input side has no backpressure: every s_axis_tvalid cycle is one consumed sample.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                  state, state_nx;
   logic [TS_WIDTH-1:0]     sample_idx;
   logic signed [DATA_WIDTH-1:0] prev_data;
   logic                    prev_valid;
   logic [TS_WIDTH-1:0]     ts_lat, ts_nx;
   logic [13:0]             fd_lat, fd_nx;
   logic [13:0]             wait_cnt, wait_nx;
   logic [13:0]             hold_cnt, hold_nx;

   logic                    above;
   logic                    prev_le;
   logic                    crossing;
   logic                    wait_done;
   logic                    hold_done;
   logic                    capture;
   logic [TS_WIDTH-1:0]     cap_ts;
   logic                    pileup_inc;
   logic                    drop_inc;

   assign above     = s_axis_tdata > threshold;
   assign prev_le   = prev_valid && (prev_data <= threshold);
   assign crossing  = s_axis_tvalid && above && prev_le;
   assign wait_done = wait_cnt == (fd_lat - 14'd1);
   // Widened so holdoff = 0x3FFF cannot wrap the increment.
   assign hold_done = ({1'b0, hold_cnt} + 15'd1) >= {1'b0, holdoff};
   assign dbg_state = state;

   always_comb begin
      state_nx   = state;
      ts_nx      = ts_lat;
      fd_nx      = fd_lat;
      wait_nx    = wait_cnt;
      hold_nx    = hold_cnt;
      capture    = 1'b0;
      cap_ts     = ts_lat;
      pileup_inc = 1'b0;
      case (state)
         ST_IDLE: begin
            if (crossing) begin
               ts_nx = sample_idx;
               fd_nx = flat_delay;
               if (flat_delay == 14'd0) begin
                  capture  = 1'b1;
                  cap_ts   = sample_idx;
                  hold_nx  = 14'd0;
                  state_nx = ST_HOLD;
               end else begin
                  wait_nx  = 14'd0;
                  state_nx = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (s_axis_tvalid) begin
               // A fresh crossing means the pulse dipped and re-rose: reject before capturing.
               if (crossing) begin
                  pileup_inc = 1'b1;
                  hold_nx    = 14'd0;
                  state_nx   = ST_HOLD;
               end else if (wait_done) begin
                  capture  = 1'b1;
                  hold_nx  = 14'd0;
                  state_nx = ST_HOLD;
               end else begin
                  wait_nx = wait_cnt + 14'd1;
               end
            end
         end
         ST_HOLD: begin
            if (s_axis_tvalid) begin
               if (above) begin
                  hold_nx    = 14'd0;
                  pileup_inc = crossing;
               end else if (hold_done) begin
                  hold_nx  = 14'd0;
                  state_nx = ST_IDLE;
               end else begin
                  hold_nx = hold_cnt + 14'd1;
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state      <= ST_IDLE;
         sample_idx <= '0;
         prev_data  <= '0;
         prev_valid <= 1'b0;
         ts_lat     <= '0;
         fd_lat     <= '0;
         wait_cnt   <= '0;
         hold_cnt   <= '0;
      end else begin
         state    <= state_nx;
         ts_lat   <= ts_nx;
         fd_lat   <= fd_nx;
         wait_cnt <= wait_nx;
         hold_cnt <= hold_nx;
         if (s_axis_tvalid) begin
            sample_idx <= sample_idx + 1'b1;
            prev_data  <= s_axis_tdata;
            prev_valid <= 1'b1;
         end
      end
   end

   // Single-entry result register; a slot freed by this cycle's handshake can take the new result.
   assign drop_inc = capture && m_axis_tvalid && !m_axis_tready;

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
      end else if (capture && !drop_inc) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= s_axis_tdata;
         m_axis_tuser  <= cap_ts;
      end else if (m_axis_tvalid && m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         pileup_count <= '0;
         drop_count   <= '0;
      end else begin
         if (pileup_inc && (pileup_count != 16'hFFFF)) begin
            pileup_count <= pileup_count + 16'd1;
         end
         if (drop_inc && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_trap_peak_picker.sv
// Directed and randomized bench for trap_peak_picker; random runs are scored against an
// array-scanning event model of the pulse stream.
module tb_trap_peak_picker;

   localparam int DW = 32;
   localparam int TW = 32;

   logic                 clk = 1'b0;
   logic                 aresetn;
   logic signed [DW-1:0] s_axis_tdata;
   logic                 s_axis_tvalid;
   logic signed [DW-1:0] threshold;
   logic [13:0]          flat_delay;
   logic [13:0]          holdoff;
   logic signed [DW-1:0] m_axis_tdata;
   logic [TW-1:0]        m_axis_tuser;
   logic                 m_axis_tvalid;
   logic                 m_axis_tready;
   logic [15:0]          pileup_count;
   logic [15:0]          drop_count;
   logic [1:0]           dbg_state;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   logic [63:0] got_q[$];
   logic [63:0] exp_q[$];
   int          stim[$];
   int          samp[$];
   int          exp_pile;

   always #5 clk = ~clk;

   trap_peak_picker #(.DATA_WIDTH(DW), .TS_WIDTH(TW)) dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .threshold     (threshold),
      .flat_delay    (flat_delay),
      .holdoff       (holdoff),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .pileup_count  (pileup_count),
      .drop_count    (drop_count),
      .dbg_state     (dbg_state)
   );

   // Beats are collected mid-cycle, where the handshake seen by the next edge is stable.
   always @(negedge clk) begin
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
         got_q.push_back({m_axis_tuser, m_axis_tdata});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return {64{1'bx}};
   endfunction

   function automatic logic [63:0] beat(input int ts, input int amp);
      logic [31:0] t;
      logic [31:0] a;
      t = ts;
      a = amp;
      return {t, a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      aresetn       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      tick();
      tick();
      aresetn = 1'b1;
      got_q.delete();
   endtask

   task automatic send(input int v);
      s_axis_tdata  = v;
      s_axis_tvalid = 1'b1;
      tick();
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_stim();
      foreach (stim[i]) send(stim[i]);
   endtask

   // Event model over the whole list of valid samples: array position is the sample index.
   function automatic bit is_cross(input int j, input int thr);
      return (j >= 1) && (samp[j] > thr) && (samp[j-1] <= thr);
   endfunction

   task automatic model(input int thr, input int fd, input int ho);
      int n;
      int k;
      n = samp.size();
      k = 1;
      exp_q.delete();
      exp_pile = 0;
      while (k < n) begin
         if (is_cross(k, thr)) begin
            int hold_from;
            int m;
            int run;
            hold_from = -1;
            if (fd == 0) begin
               exp_q.push_back(beat(k, samp[k]));
               hold_from = k;
            end else begin
               for (int j = k + 1; j <= k + fd && j < n; j++) begin
                  if (is_cross(j, thr)) begin
                     exp_pile++;
                     hold_from = j;
                     break;
                  end else if (j == k + fd) begin
                     exp_q.push_back(beat(k, samp[j]));
                     hold_from = j;
                     break;
                  end
               end
            end
            if (hold_from < 0) break;
            run = 0;
            m = hold_from + 1;
            while (m < n) begin
               if (samp[m] > thr) begin
                  run = 0;
                  if (is_cross(m, thr)) exp_pile++;
               end else begin
                  run++;
                  if (run >= ho) break;
               end
               m++;
            end
            k = m + 1;
         end else begin
            k++;
         end
      end
   endtask

   initial begin
      threshold     = 100;
      flat_delay    = 14'd4;
      holdoff       = 14'd3;
      m_axis_tready = 1'b1;
      do_reset();

      // Reset values
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tuser", m_axis_tuser, 0);
      check("rst_pileup", pileup_count, 0);
      check("rst_drop", drop_count, 0);
      check("rst_state", dbg_state, 0);

      // Basic trapezoid, crossing at index 10, flat-top captured 4 samples later
      stim = '{0,0,0,0,0,0,0,0,0,0, 250,500,750,1000,1000,1000,1000,1000,1000,
               750,500,250,0,0,0,0,0,0};
      send_stim();
      check("t1_beats", got_q.size(), 1);
      check("t1_beat", got_at(0), beat(10, 1000));
      check("t1_pileup", pileup_count, 0);
      check("t1_drop", drop_count, 0);
      check("t1_state", dbg_state, 0);

      // flat_delay 0: the crossing sample itself, valid one cycle later
      do_reset();
      flat_delay = 14'd0;
      stim = '{0,0,0};
      send_stim();
      check("t2_pre_tvalid", m_axis_tvalid, 0);
      send(250);
      check("t2_tvalid", m_axis_tvalid, 1);
      check("t2_tdata", m_axis_tdata, 250);
      check("t2_tuser", m_axis_tuser, 3);
      stim = '{500,750,1000,1000,500,250,0,0,0,0};
      send_stim();
      check("t2_beats", got_q.size(), 1);

      // Re-crossing inside holdoff
      do_reset();
      flat_delay = 14'd4;
      stim = '{0,0,0,250,500,750,1000,1000,1000,1000,500,0,0,400,800,800,500,0,0,0,0};
      send_stim();
      check("t3_beats", got_q.size(), 1);
      check("t3_beat", got_at(0), beat(3, 1000));
      check("t3_pileup", pileup_count, 1);

      // Dip and re-cross while waiting for the flat-top
      do_reset();
      flat_delay = 14'd6;
      stim = '{0,0,0,250,600,50,600,900,900};
      send_stim();
      check("t4_state_hold", dbg_state, 2);
      check("t4_pileup", pileup_count, 1);
      stim = '{0,0,0,0,0};
      send_stim();
      check("t4_beats", got_q.size(), 0);
      check("t4_state_idle", dbg_state, 0);

      // Backpressure across two pulses: the second result is dropped
      do_reset();
      flat_delay    = 14'd2;
      m_axis_tready = 1'b0;
      stim = '{0,0,0,300,500,500,500,0,0,0,0, 300,700,700,700,0,0,0,0};
      send_stim();
      check("t5_tvalid", m_axis_tvalid, 1);
      check("t5_tdata", m_axis_tdata, 500);
      check("t5_tuser", m_axis_tuser, 3);
      check("t5_drop", drop_count, 1);
      check("t5_no_beat", got_q.size(), 0);
      m_axis_tready = 1'b1;
      tick();
      check("t5_tvalid_after", m_axis_tvalid, 0);
      repeat (3) tick();
      check("t5_beats", got_q.size(), 1);
      check("t5_beat", got_at(0), beat(3, 500));

      // Reset in the middle of an event
      do_reset();
      flat_delay = 14'd4;
      stim = '{0,0,0,250,500};
      send_stim();
      check("t6_state_wait", dbg_state, 1);
      do_reset();
      check("t6_rst_state", dbg_state, 0);
      check("t6_rst_tvalid", m_axis_tvalid, 0);
      stim = '{0,0,0,0,0,0,0,0,0,0, 250,500,750,1000,1000,1000,1000,500,0,0,0,0};
      send_stim();
      check("t6_beats", got_q.size(), 1);
      check("t6_beat", got_at(0), beat(10, 1000));
      check("t6_pileup", pileup_count, 0);

      // Random pulse trains with gaps in s_axis_tvalid
      for (int round = 0; round < 4; round++) begin
         int thr;
         int fd;
         int ho;
         thr = int'($urandom_range(50, 300));
         fd  = int'($urandom_range(0, 6));
         ho  = int'($urandom_range(0, 5));
         threshold  = thr;
         flat_delay = 14'(fd);
         holdoff    = 14'(ho);
         do_reset();
         samp.delete();
         repeat (6) samp.push_back(int'($urandom_range(0, 80)) - 40);
         for (int p = 0; p < 25; p++) begin
            int amp;
            int rise;
            int flat;
            int fall;
            int gap;
            gap  = int'($urandom_range(0, 6));
            amp  = int'($urandom_range(20, 1500));
            rise = int'($urandom_range(1, 4));
            flat = int'($urandom_range(1, 8));
            fall = int'($urandom_range(1, 4));
            for (int r = 1; r <= rise; r++) samp.push_back(amp * r / rise);
            for (int r = 0; r < flat; r++) samp.push_back(amp);
            for (int r = 1; r <= fall; r++) samp.push_back(amp * (fall - r) / fall);
            for (int r = 0; r < gap; r++) samp.push_back(int'($urandom_range(0, 80)) - 40);
         end
         repeat (12) samp.push_back(0);
         foreach (samp[i]) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(samp[i]);
         end
         repeat (3) tick();
         model(thr, fd, ho);
         check($sformatf("r%0d_beats", round), got_q.size(), exp_q.size());
         foreach (exp_q[i]) check($sformatf("r%0d_beat%0d", round, i), got_at(i), exp_q[i]);
         check($sformatf("r%0d_pileup", round), pileup_count, exp_pile);
         check($sformatf("r%0d_drop", round), drop_count, 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
